mappy_obj_ram: RTL
==================

Name: mappy_obj_ram

Overview:
Sprite attribute RAM responder for the video block's sprite fetch engine. It holds three 2 KB banks (obj1, obj2, obj3) that the video side reads in parallel at the same index during the hblank sprite scan. The CPU side writes and reads them through a request/ack handshake. An arbiter stalls CPU accesses while the video side owns the banks, and a clear engine fills all banks after reset.

Parameters:
ADDR_W, 11, per-bank address width (2048 bytes per bank)
CLEAR_VAL, 8'h00, byte written to every location by the clear engine

Ports:
clk_18432  in  1  single clock for all logic
reset  in  1  asynchronous, active-high reset
vid_active  in  1  video sprite-fetch window; video side owns all banks while high
vid_addr1  in  11  obj1 bank read address (driven from AB_obj1)
vid_addr2  in  11  obj2 bank read address (driven from AB_obj2)
vid_addr3  in  11  obj3 bank read address (driven from AB_obj3)
vid_data1  out  8  obj1 read data (to obj1in)
vid_data2  out  8  obj2 read data (to obj2in)
vid_data3  out  8  obj3 read data (to obj3in)
cpu_req  in  1  access request, level
cpu_we  in  1  1 = write, 0 = read; sampled with the request
cpu_addr  in  13  {bank[1:0], offset[10:0]}; bank 0/1/2 = obj1/obj2/obj3
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, valid while cpu_ack is high
cpu_ack  out  1  one-cycle completion pulse
clear_done  out  1  high once the post-reset clear has finished

Behaviour:
- Reset (asynchronous) values:
  - state = CLEAR, clear counter = 0.
  - cpu_ack = 0, cpu_rdata = 0, vid_data1..3 = 0, clear_done = 0.
  - RAM contents are undefined until the clear completes.
- Each bank is a single-port synchronous RAM. The bank port is muxed between video, CPU and clear.
- States:
  - CLEAR:
    - Writes CLEAR_VAL at counter address to all three banks each cycle.
    - Counter runs 0..2047. At 2047 the state goes to IDLE and clear_done is set, staying 1 until reset.
    - vid_data1..3 are forced to CLEAR_VAL.
    - cpu_req is ignored; no ack is produced.
  - IDLE:
    - If cpu_req=1 and vid_active=0: capture cpu_we/addr/wdata, issue the RAM op on the addressed bank, and go to CPU_ACC.
    - If vid_active=1: the CPU request is held pending; there is no timeout.
  - CPU_ACC: RAM output settles; go to CPU_ACK unconditionally.
  - CPU_ACK:
    - cpu_ack=1 for exactly this cycle.
    - cpu_rdata = RAM byte for a read; for a write it holds its previous value.
    - Return to IDLE.
- Handshake timing:
  - Request accepted at edge N gives ack high in the cycle after edge N+1.
  - cpu_req held high continuously produces one access every 3 cycles.
  - The requester must drop cpu_req in the ack cycle to avoid a repeat access.
- Bank code 3:
  - No RAM write.
  - Read returns 8'hFF.
  - Same 3-cycle timing and ack.
- Video reads:
  - Registered, one-cycle latency: an address sampled at edge N gives data valid after edge N.
  - All three banks are read at their own addresses in the same cycle.
- vid_active rising while in CPU_ACC or CPU_ACK:
  - The committed CPU access completes normally.
  - Only the bank addressed by the CPU is held: its vid_data holds its previous value for those cycles.
  - The other two banks keep serving video.
  - The video side guards the first 2 cycles of its window.
- Video reads in IDLE with vid_active=0 are still serviced every cycle. Arbitration only blocks the CPU.
- Write/read to the same address: a CPU read after a CPU write returns the new data. A video read in the cycle after the write's CPU_ACC edge returns the new data.
- Reset asserted mid-CLEAR or mid-CPU access:
  - Immediate return to CLEAR with the counter at 0.
  - Any pending ack is dropped.
  - The full 2048-cycle clear repeats.

Test Plan:
- Release reset, then hold vid_active=0 -> clear_done rises exactly 2048 cycles after reset deassert; vid_addr1..3=0x7FF reads 0x00 on all banks.
- After clear, CPU write bank1 addr 0x780 data 0x5A; then vid_addr2=0x780 -> cpu_ack pulses 2 cycles after acceptance; vid_data2=0x5A the next cycle; vid_data1 and vid_data3 remain 0x00.
- Hold vid_active=1 for 20 cycles with cpu_req=1 (read bank0 0x7FF, preloaded 0xC3) -> no ack while vid_active is high; ack 2 cycles after vid_active falls; cpu_rdata=0xC3.
- Write bank code 3 data 0x11, then read bank code 3 -> both acked; read returns 0xFF; banks 0-2 unchanged.
- cpu_req held high for 9 cycles (writes) -> exactly 3 acks, spaced 3 cycles apart.
- Assert reset at clear count 1000, release -> clear_done low until a full 2048 cycles after release; no cpu_ack generated meanwhile.

Source files
------------

// File: rtl/mappy_obj_ram_if.sv
// CPU request/ack bus into the sprite attribute RAM: {bank, offset} address,
// level request, one-cycle ack with read data.
interface mappy_obj_ram_if #(
    parameter int ADDR_W = 11
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W+1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack
    );
endinterface

// File: rtl/mappy_obj_ram.sv
// Three-bank sprite attribute RAM: parallel video reads, arbitrated CPU
// request/ack access, and a post-reset clear engine that fills every bank.
module mappy_obj_ram #(
    parameter int         ADDR_W    = 11,
    parameter logic [7:0] CLEAR_VAL = 8'h00
) (
    input  logic              clk_18432,
    input  logic              reset,
    input  logic              vid_active,
    input  logic [ADDR_W-1:0] vid_addr1,
    input  logic [ADDR_W-1:0] vid_addr2,
    input  logic [ADDR_W-1:0] vid_addr3,
    output logic [7:0]        vid_data1,
    output logic [7:0]        vid_data2,
    output logic [7:0]        vid_data3,
    mappy_obj_ram_if.slave    cpu,
    output logic              clear_done
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ACC   = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
    logic              clear_done_q, clear_done_d;
    logic              cpu_ack_q,    cpu_ack_d;
    logic [7:0]        cpu_rdata_q,  cpu_rdata_d;
    logic              acc_we_q,     acc_we_d;
    logic [1:0]        acc_bank_q,   acc_bank_d;

    logic [7:0]        mem [3][DEPTH];
    logic [7:0]        ram_cpu_q;
    logic [7:0]        vid_data_q [3];

    logic              accept;
    logic [1:0]        req_bank;
    logic [ADDR_W-1:0] req_off;
    logic [ADDR_W-1:0] vid_addr [3];
    logic [2:0]        cpu_own;
    logic [2:0]        port_we;
    logic [ADDR_W-1:0] port_addr [3];
    logic [7:0]        port_din;

    assign req_bank    = cpu.cpu_addr[ADDR_W+1:ADDR_W];
    assign req_off     = cpu.cpu_addr[ADDR_W-1:0];
    assign accept      = (state_q == ST_IDLE) && cpu.cpu_req && !vid_active;
    assign vid_addr[0] = vid_addr1;
    assign vid_addr[1] = vid_addr2;
    assign vid_addr[2] = vid_addr3;

    // Bank port mux: clear engine, then the CPU on its addressed bank, else video.
    // The CPU keeps its bank through CPU_ACC so video data on it holds until ack.
    always_comb begin
        port_din = (state_q == ST_CLEAR) ? CLEAR_VAL : cpu.cpu_wdata;
        for (int b = 0; b < 3; b++) begin
            cpu_own[b]   = (accept && req_bank == 2'(b)) ||
                           (state_q == ST_ACC && acc_bank_q == 2'(b));
            port_we[b]   = 1'b0;
            port_addr[b] = vid_addr[b];
            if (state_q == ST_CLEAR) begin
                port_we[b]   = 1'b1;
                port_addr[b] = clr_cnt_q;
            end else if (accept && req_bank == 2'(b)) begin
                port_we[b]   = cpu.cpu_we;
                port_addr[b] = req_off;
            end
        end
    end

    always_ff @(posedge clk_18432) begin
        for (int b = 0; b < 3; b++) begin
            if (port_we[b]) mem[b][port_addr[b]] <= port_din;
            if (accept && req_bank == 2'(b)) ram_cpu_q <= mem[b][req_off];
        end
    end

    always_ff @(posedge clk_18432 or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) vid_data_q[b] <= 8'h00;
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (state_q == ST_CLEAR) vid_data_q[b] <= CLEAR_VAL;
                else if (!cpu_own[b])    vid_data_q[b] <= mem[b][vid_addr[b]];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        clear_done_d = clear_done_q;
        cpu_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        acc_we_d     = acc_we_q;
        acc_bank_d   = acc_bank_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == '1) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    acc_we_d   = cpu.cpu_we;
                    acc_bank_d = req_bank;
                    state_d    = ST_ACC;
                end
            end
            ST_ACC: begin
                state_d   = ST_ACK;
                cpu_ack_d = 1'b1;
                if (!acc_we_q) cpu_rdata_d = (acc_bank_q == 2'd3) ? 8'hFF : ram_cpu_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_18432 or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b0;
            cpu_ack_q    <= 1'b0;
            cpu_rdata_q  <= 8'h00;
            acc_we_q     <= 1'b0;
            acc_bank_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clear_done_q <= clear_done_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_rdata_q  <= cpu_rdata_d;
            acc_we_q     <= acc_we_d;
            acc_bank_q   <= acc_bank_d;
        end
    end

    assign vid_data1     = vid_data_q[0];
    assign vid_data2     = vid_data_q[1];
    assign vid_data3     = vid_data_q[2];
    assign cpu.cpu_ack   = cpu_ack_q;
    assign cpu.cpu_rdata = cpu_rdata_q;
    assign clear_done    = clear_done_q;
endmodule
